// File: rtl/paula_audio_mixer_seq_if.sv
// Mixer request/result bundle between the Paula channel logic and the mixer.
//   master : drives mix_req, aen, sample0-3, vol0-3; receives the mix results
//   slave  : the mixer itself; receives the channel inputs and drives
//            ldatasum, rdatasum, mix_done, busy and overrun
interface paula_audio_mixer_seq_if #(
  parameter int SAMPLE_W = 8,
  parameter int VOL_W    = 7,
  parameter int OUT_W    = 15
);
  logic                mix_req;
  logic [3:0]          aen;
  logic [SAMPLE_W-1:0] sample0, sample1, sample2, sample3;
  logic [VOL_W-1:0]    vol0, vol1, vol2, vol3;
  logic [OUT_W-1:0]    ldatasum, rdatasum;
  logic                mix_done, busy, overrun;

  modport master (
    output mix_req, aen, sample0, sample1, sample2, sample3, vol0, vol1, vol2, vol3,
    input  ldatasum, rdatasum, mix_done, busy, overrun
  );
  modport slave (
    input  mix_req, aen, sample0, sample1, sample2, sample3, vol0, vol1, vol2, vol3,
    output ldatasum, rdatasum, mix_done, busy, overrun
  );
endinterface

// File: rtl/paula_audio_mixer_seq.sv
// Paula four-channel volume scaler and stereo summer (left = ch0+ch3,
// right = ch1+ch2). One shared signed multiplier is stepped through the four
// channels by a six-state sequencer that advances only on clk7_en ticks.
//   clk, reset_n : bus clock, async active-low reset
//   clk7_en      : tick enable; every register holds while low
//   bus          : slave side of paula_audio_mixer_seq_if (request, channel
//                  samples/volumes, mix results and status)
module paula_audio_mixer_seq #(
  parameter int SAMPLE_W = 8,
  parameter int VOL_W    = 7,
  parameter int OUT_W    = 15,
  parameter int VOL_MAX  = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk7_en,
  paula_audio_mixer_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, L0, L3, R1, R2, COMMIT} state_t;

  state_t state_q, state_d;

  logic [3:0][SAMPLE_W-1:0] in_s, snap_s;
  logic [3:0][VOL_W-1:0]    in_v, eff_v, snap_v;

  logic signed [OUT_W-1:0] acc_l, acc_r, ldat_q, rdat_q;
  logic signed [OUT_W-1:0] mul_a, mul_b, prod;
  logic signed [SAMPLE_W-1:0] mul_s;
  logic [VOL_W-1:0]           mul_v;
  logic [1:0] sel;
  logic       snap_en, pending, overrun_q, done_q, busy_q;

  assign in_s = {bus.sample3, bus.sample2, bus.sample1, bus.sample0};
  assign in_v = {bus.vol3, bus.vol2, bus.vol1, bus.vol0};

  // Effective volume: disabled channel -> 0, any value with the MSB set
  // (64..127) clamps to full scale, otherwise pass through.
  for (genvar ch = 0; ch < 4; ch++) begin : g_effvol
    assign eff_v[ch] = !bus.aen[ch]          ? '0 :
                       in_v[ch][VOL_W-1]     ? VOL_W'(VOL_MAX) :
                                               in_v[ch];
  end

  // Shared multiplier operand select follows the sequencer order 0,3,1,2.
  always_comb begin
    sel = 2'd0;
    case (state_q)
      L3:      sel = 2'd3;
      R1:      sel = 2'd1;
      R2:      sel = 2'd2;
      default: sel = 2'd0;
    endcase
  end

  assign mul_s = snap_s[sel];
  assign mul_v = snap_v[sel];
  // Sample is sign-extended, volume zero-extended; the true product fits in
  // OUT_W bits so truncating the multiply result loses nothing.
  assign mul_a = OUT_W'(mul_s);
  assign mul_b = OUT_W'(mul_v);
  assign prod  = mul_a * mul_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else if (clk7_en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    snap_en = 1'b0;
    case (state_q)
      IDLE:   if (bus.mix_req) begin state_d = L0; snap_en = 1'b1; end
      L0:     state_d = L3;
      L3:     state_d = R1;
      R1:     state_d = R2;
      R2:     state_d = COMMIT;
      COMMIT: if (pending || bus.mix_req) begin
                state_d = L0;
                snap_en = 1'b1;
              end else begin
                state_d = IDLE;
              end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_s    <= '0;
      snap_v    <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      ldat_q    <= '0;
      rdat_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (clk7_en) begin
      if (snap_en) begin
        snap_s <= in_s;
        snap_v <= eff_v;
      end
      done_q <= (state_q == COMMIT);
      busy_q <= (state_d != IDLE);
      case (state_q)
        L0: acc_l <= prod;
        L3: acc_l <= acc_l + prod;
        R1: acc_r <= prod;
        R2: acc_r <= acc_r + prod;
        COMMIT: begin
          ldat_q <= acc_l;
          rdat_q <= acc_r;
        end
        default: ;
      endcase
      // One-deep request queue while a round is in flight. In COMMIT the
      // queued request is consumed; a fresh request arriving alongside it
      // has nowhere to go and is counted as dropped.
      if (state_q inside {L0, L3, R1, R2}) begin
        if (bus.mix_req) begin
          if (pending) overrun_q <= 1'b1;
          else         pending   <= 1'b1;
        end
      end else if (state_q == COMMIT) begin
        if (pending && bus.mix_req) overrun_q <= 1'b1;
        pending <= 1'b0;
      end
    end
  end

  assign bus.ldatasum = ldat_q;
  assign bus.rdatasum = rdat_q;
  assign bus.mix_done = done_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_paula_audio_mixer_seq.sv
module tb_paula_audio_mixer_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clk7_en = 1'b1;
  int nvec = 0;
  int nerr = 0;

  paula_audio_mixer_seq_if #(.SAMPLE_W(8), .VOL_W(7), .OUT_W(15)) bus ();

  paula_audio_mixer_seq #(.SAMPLE_W(8), .VOL_W(7), .OUT_W(15), .VOL_MAX(64)) dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input logic [3:0] en,
                        input logic [7:0] s0, input logic [6:0] v0,
                        input logic [7:0] s1, input logic [6:0] v1,
                        input logic [7:0] s2, input logic [6:0] v2,
                        input logic [7:0] s3, input logic [6:0] v3);
    bus.aen = en;
    bus.sample0 = s0; bus.vol0 = v0;
    bus.sample1 = s1; bus.vol1 = v1;
    bus.sample2 = s2; bus.vol2 = v2;
    bus.sample3 = s3; bus.vol3 = v3;
  endtask

  // One request, then five ticks; check done timing and both sums.
  task automatic round(input string tag, input logic [14:0] el, input logic [14:0] er);
    bus.mix_req = 1'b1;
    tick();
    bus.mix_req = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 4; i++) tick();
    chk({tag, "_early_done"}, 32'(bus.mix_done), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(bus.mix_done), 32'd1);
    chk({tag, "_l"}, 32'(bus.ldatasum), 32'(el));
    chk({tag, "_r"}, 32'(bus.rdatasum), 32'(er));
    tick();
    chk({tag, "_done_clr"}, 32'(bus.mix_done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.mix_req = 1'b0;
    set_ch(4'hF, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0);
    #1;
    chk("rst_l", 32'(bus.ldatasum), 32'd0);
    chk("rst_r", 32'(bus.rdatasum), 32'd0);
    chk("rst_done", 32'(bus.mix_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    tick();

    // T2 left full scale: 127*64*2 = 16256
    set_ch(4'hF, 8'h7F, 7'd64, 8'h00, 7'd64, 8'h00, 7'd64, 8'h7F, 7'd64);
    round("t2", 15'h3F80, 15'h0000);

    // T3 right negative full scale: -128*64*2 = -16384
    set_ch(4'hF, 8'h00, 7'd64, 8'h80, 7'd64, 8'h80, 7'd64, 8'h00, 7'd64);
    round("t3", 15'h0000, 15'h4000);

    // T4 volume clamp and channel enable
    set_ch(4'hF, 8'h01, 7'h7F, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0);
    round("t4_clamp", 15'h0040, 15'h0000);
    set_ch(4'hE, 8'h01, 7'h7F, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0);
    round("t4_aen", 15'h0000, 15'h0000);
    // L: -2*63 + 3*64(clamped 100) = 66; R: 5*10 + -7*64 = -398
    set_ch(4'hF, 8'hFE, 7'd63, 8'h05, 7'd10, 8'hF9, 7'd64, 8'h03, 7'd100);
    round("t4_mix", 15'h0042, 15'h7E72);

    // T1 reset while the sequencer sits in R1
    bus.mix_req = 1'b1;
    tick();
    bus.mix_req = 1'b0;
    tick(); tick();
    chk("t1_busy_pre", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t1_l", 32'(bus.ldatasum), 32'd0);
    chk("t1_r", 32'(bus.rdatasum), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick();
    chk("t1_idle", 32'(bus.busy), 32'd0);
    chk("t1_done", 32'(bus.mix_done), 32'd0);

    // T5 queueing: requests at ticks 0 and 2; sample changed after the first
    // snapshot so the queued round picks up the new value.
    set_ch(4'hF, 8'd10, 7'd2, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0);
    for (int t = 0; t <= 11; t++) begin
      bus.mix_req = (t == 0 || t == 2);
      tick();
      if (t == 0) bus.sample0 = 8'd20;
      if (t == 5) begin
        chk("t5_done5", 32'(bus.mix_done), 32'd1);
        chk("t5_l5", 32'(bus.ldatasum), 32'h14);
        chk("t5_busy5", 32'(bus.busy), 32'd1);
      end else if (t == 10) begin
        chk("t5_done10", 32'(bus.mix_done), 32'd1);
        chk("t5_l10", 32'(bus.ldatasum), 32'h28);
      end else if (t == 4 || t == 9 || t == 11) begin
        chk($sformatf("t5_nodone%0d", t), 32'(bus.mix_done), 32'd0);
      end
    end
    bus.mix_req = 1'b0;
    chk("t5_ovr0", 32'(bus.overrun), 32'd0);
    chk("t5_idle", 32'(bus.busy), 32'd0);

    // Third request while one is already queued -> overrun
    for (int t = 0; t <= 11; t++) begin
      bus.mix_req = (t == 0 || t == 2 || t == 3);
      tick();
      if (t == 2) chk("t5_ovr_pre", 32'(bus.overrun), 32'd0);
      if (t == 3) chk("t5_ovr_set", 32'(bus.overrun), 32'd1);
    end
    bus.mix_req = 1'b0;
    chk("t5_ovr_sticky", 32'(bus.overrun), 32'd1);

    // T6 clk7_en gating mid-round
    set_ch(4'hF, 8'h7F, 7'd64, 8'h00, 7'd64, 8'h00, 7'd64, 8'h7F, 7'd64);
    bus.mix_req = 1'b1;
    tick();
    bus.mix_req = 1'b0;
    tick(); tick();
    clk7_en = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_frozen_busy", 32'(bus.busy), 32'd1);
    chk("t6_frozen_l", 32'(bus.ldatasum), 32'h28);
    chk("t6_frozen_done", 32'(bus.mix_done), 32'd0);
    clk7_en = 1'b1;
    tick();
    chk("t6_early", 32'(bus.mix_done), 32'd0);
    tick();
    chk("t6_early2", 32'(bus.mix_done), 32'd0);
    tick();
    chk("t6_done", 32'(bus.mix_done), 32'd1);
    chk("t6_l", 32'(bus.ldatasum), 32'h3F80);
    clk7_en = 1'b0;
    tick(); tick(); tick();
    chk("t6_done_hold", 32'(bus.mix_done), 32'd1);
    clk7_en = 1'b1;
    tick();
    chk("t6_done_clr", 32'(bus.mix_done), 32'd0);
    chk("t6_idle", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
